// File: rtl/vga_pkg.sv
// Purpose: shared timing constants for the VGA raster generator (640x480@60 defaults).
// Latency: n/a (constants only).
// Backpressure: n/a; the raster runs free and never stalls.
package vga_pkg;

  // Counter width; both totals must fit in 2**POS_W.
  localparam int POS_W = 10;

  // Default 640x480@60 horizontal timing, in pixel clocks.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  // Default vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Derived totals and sync windows (sync is low for START <= pos < END).
  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Sync/blank pipeline depth matching the downstream colour stage.
  localparam int SYNC_DLY_DEF = 2;

  // Idle level of the delayed {display_on, hsync, vsync} bundle.
  localparam logic [2:0] SYNC_IDLE = 3'b011;

endpackage

// File: rtl/sync_delay.sv
// Purpose: fixed-depth shift register with synchronous reset to a programmable idle value.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every clock.
//
// Ports:
//   clock  in          rising-edge clock
//   reset  in          synchronous active-high reset, loads RESET_VAL into every stage
//   din    in  WIDTH   data entering stage 0
//   dout   out WIDTH   data leaving the last stage
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Purpose: free-running VGA raster counters with decoded blank/sync.
// Latency: hpos/vpos/line_start/frame_start immediate; display_on/hsync/vsync delayed SYNC_DLY cycles.
// Backpressure: none; the raster never stalls.
//
// Ports:
//   clock        in       pixel clock, rising edge
//   reset        in       synchronous active-high reset
//   hpos, vpos   out 10   raster counters (the registers themselves)
//   line_start   out      high while hpos==0 (and not in reset)
//   frame_start  out      high while hpos==0 and vpos==0 (and not in reset)
//   display_on   out      active video, delayed SYNC_DLY cycles
//   hsync, vsync out      active-low syncs, delayed SYNC_DLY cycles
//   frame        out 8    frame counter when VGA_FRAME_CNT_EN is defined, else 0
//
// Optional feature macro: VGA_FRAME_CNT_EN (enables the 8-bit frame counter).
// SYNC_DLY must be in 1..8; H and V totals must each be <= 1024.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_DLY = SYNC_DLY_DEF
) (
  input  logic             clock,
  input  logic             reset,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic             display_on,
  output logic             hsync,
  output logic             vsync,
  output logic [7:0]       frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Position-width copies of the decode boundaries keep comparisons width-matched.
  localparam logic [POS_W-1:0] H_MAX    = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_MAX    = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_START = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_START = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] decode;
  logic [2:0] decode_dly;

  assign h_wrap = (hpos == H_MAX);
  assign v_wrap = (vpos == V_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else if (h_wrap) begin
      hpos <= '0;
      vpos <= v_wrap ? '0 : vpos + 1'b1;
    end else begin
      hpos <= hpos + 1'b1;
    end
  end

  // Gated by reset so the pulses stay quiet while the counters are held at 0.
  assign line_start  = (hpos == '0) && !reset;
  assign frame_start = (hpos == '0) && (vpos == '0) && !reset;

  // {display_on, hsync, vsync}; syncs are active-low, vsync spans whole lines.
  always_comb begin
    decode    = SYNC_IDLE;
    decode[2] = (hpos < H_ACT) && (vpos < V_ACT);
    decode[1] = !((hpos >= HS_START) && (hpos < HS_END));
    decode[0] = !((vpos >= VS_START) && (vpos < VS_END));
  end

  sync_delay #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DLY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .din   (decode),
    .dout  (decode_dly)
  );

  assign {display_on, hsync, vsync} = decode_dly;

`ifdef VGA_FRAME_CNT_EN
  // Steps on the same edge the raster returns to (0,0); wraps naturally at 8 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame <= '0;
    end else if (h_wrap && v_wrap) begin
      frame <= frame + 8'd1;
    end
  end
`else
  assign frame = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  logic clk;
  logic reset;

  // Default 640x480 instance.
  logic [9:0] d_hpos, d_vpos;
  logic       d_line_start, d_frame_start, d_display_on, d_hsync, d_vsync;
  logic [7:0] d_frame;

  // Small-raster instance (16x10 totals, SYNC_DLY=3) so whole frames fit the cycle budget.
  logic [9:0] s_hpos, s_vpos;
  logic       s_line_start, s_frame_start, s_display_on, s_hsync, s_vsync;
  logic [7:0] s_frame;

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing u_dut (
    .clock       (clk),
    .reset       (reset),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .line_start  (d_line_start),
    .frame_start (d_frame_start),
    .display_on  (d_display_on),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .frame       (d_frame)
  );

  vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_DLY (3)
  ) u_dut_small (
    .clock       (clk),
    .reset       (reset),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .display_on  (s_display_on),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .frame       (s_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_frame(input int n);
`ifdef VGA_FRAME_CNT_EN
    return n % 256;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    int walk_err = 0, ls_cnt = 0, ls_last = -1;
    int hs_first = -1, hs_len = 0, de_first = -1, de_len = 0, early_de = 0;
    int guard = 0;
    int fs_cnt = 0, fs_prev = -1, fs_gap = -1;
    int svs_first = -1, svs_len = 0, sde_len = 0, shs_first = -1, shs_len = 0;

    reset = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_hpos",        d_hpos,        0);
    check("rst_vpos",        d_vpos,        0);
    check("rst_display_on",  d_display_on,  0);
    check("rst_hsync",       d_hsync,       1);
    check("rst_vsync",       d_vsync,       1);
    check("rst_line_start",  d_line_start,  0);
    check("rst_frame_start", d_frame_start, 0);
    check("rst_frame",       d_frame,       0);

    // Release: cycle 0 shows (0,0) with both start pulses.
    reset = 1'b0;
    #1;
    check("rel_line_start",  d_line_start,  1);
    check("rel_frame_start", d_frame_start, 1);

    // Walk the first line plus one cycle of the default raster.
    for (int c = 0; c <= 800; c++) begin
      if (d_hpos != 10'(c % 800) || d_vpos != 10'(c / 800)) walk_err++;
      if (d_line_start) begin
        ls_cnt++;
        ls_last = c;
      end
      if (!d_hsync) begin
        if (hs_first < 0) hs_first = d_hpos;
        hs_len++;
      end
      if (d_display_on) begin
        if (de_first < 0) de_first = d_hpos;
        de_len++;
        if (c < 2) early_de++;
      end
      if (c < 800) step();
    end
    check("walk_errors",     walk_err, 0);
    check("line_start_cnt",  ls_cnt,   2);
    check("line_start_last", ls_last,  800);
    check("wrap_hpos",       d_hpos,   0);
    check("wrap_vpos",       d_vpos,   1);
    check("hsync_first_h",   hs_first, 658);
    check("hsync_low_len",   hs_len,   96);
    check("de_first_h",      de_first, 2);
    check("de_len",          de_len,   640);
    check("de_idle_early",   early_de, 0);
    check("vsync_line1",     d_vsync,  1);

    // Mid-line reset while hsync is low.
    while (d_hpos != 10'd700 && guard < 1000) begin
      step();
      guard++;
    end
    check("reach_h700",     d_hpos,  700);
    check("hsync_low_h700", d_hsync, 0);
    reset = 1'b1;
    step();
    check("mid_rst_hpos",       d_hpos,       0);
    check("mid_rst_vpos",       d_vpos,       0);
    check("mid_rst_hsync",      d_hsync,      1);
    check("mid_rst_display_on", d_display_on, 0);
    check("mid_rst_line_start", d_line_start, 0);
    check("mid_rst_frame",      d_frame,      0);
    reset = 1'b0;
    #1;
    check("post_rst_line_start", d_line_start, 1);
    check("post_rst_de_c0",      d_display_on, 0);
    step();
    check("post_rst_de_c1",      d_display_on, 0);
    step();
    check("post_rst_de_c2",      d_display_on, 1);
    check("post_rst_hpos_c2",    d_hpos,       2);

    // Small raster: two frames of sync/blank checks, then 256 frames for the counter.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c <= 256 * 160; c++) begin
      if (c < 320) begin
        if (s_frame_start) begin
          fs_cnt++;
          if (fs_prev >= 0) fs_gap = c - fs_prev;
          fs_prev = c;
        end
        if (!s_vsync) begin
          if (svs_first < 0) svs_first = c;
          svs_len++;
        end
        if (!s_hsync) begin
          if (shs_first < 0) shs_first = c;
          shs_len++;
        end
        if (s_display_on) sde_len++;
      end
      if (c == 16) begin
        check("s_wrap_hpos", s_hpos, 0);
        check("s_wrap_vpos", s_vpos, 1);
      end
      if (c == 159)       check("s_frame_c159",   s_frame, exp_frame(0));
      if (c == 160)       check("s_frame_1",      s_frame, exp_frame(1));
      if (c == 255 * 160) check("s_frame_255",    s_frame, exp_frame(255));
      if (c == 256 * 160) check("s_frame_wrap",   s_frame, exp_frame(256));
      if (c < 256 * 160) step();
    end
    check("s_frame_start_cnt", fs_cnt,    2);
    check("s_frame_period",    fs_gap,    160);
    check("s_vsync_first",     svs_first, 115);
    check("s_vsync_len",       svs_len,   64);
    check("s_hsync_first",     shs_first, 13);
    check("s_hsync_len",       shs_len,   60);
    check("s_de_len",          sde_len,   96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster timing generator. Produces pixel coordinates, blanking and sync for 640x480@60 (25.175 MHz nominal pixel clock). Sits directly upstream of the pixel/colour stage in `top`: that stage renders `r`/`g`/`b` from `hpos`/`vpos`, and this block's delayed `hsync`/`vsync`/`display_on` are sized so sync stays aligned with the colour pipeline's latency.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: hsync pulse width.
- `H_BP`, 48: horizontal back porch. H_TOTAL = 800.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vsync width in lines.
- `V_BP`, 33: vertical back porch. V_TOTAL = 525.
- `SYNC_DLY`, 2: register stages on sync/blank outputs, range 1..8, matches downstream colour latency.

Ports:
- `clock`  in  1  pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hpos`  out  10  horizontal counter, 0..H_TOTAL-1.
- `vpos`  out  10  vertical counter, 0..V_TOTAL-1.
- `line_start`  out  1  high while `hpos`==0 and `reset` low.
- `frame_start`  out  1  high while `hpos`==0, `vpos`==0 and `reset` low.
- `display_on`  out  1  active-video flag, delayed SYNC_DLY cycles.
- `hsync`  out  1  active-low horizontal sync, delayed SYNC_DLY cycles.
- `vsync`  out  1  active-low vertical sync, delayed SYNC_DLY cycles.
- `frame`  out  8  frame counter (see Configuration).

## Operation

- `hpos`/`vpos` are the counter registers themselves, with no extra output register.
- Each clock with `reset` low:
  - `hpos` increments.
  - At `hpos`==H_TOTAL-1, `hpos` wraps to 0 and `vpos` increments.
  - When both are at their maxima, both wrap to 0.
- Decode is combinational from the counters, then fed into a SYNC_DLY-deep shift register:
  - active video: `hpos` < H_ACTIVE and `vpos` < V_ACTIVE.
  - hsync low: H_ACTIVE+H_FP ≤ `hpos` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync low: V_ACTIVE+V_FP ≤ `vpos` < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the whole line including blanking.
- `line_start` and `frame_start` are combinational from the counters and are not delayed. They are single-cycle pulses: `line_start` once per line, `frame_start` once per frame.
- Counter widths are fixed at 10 bits; H_TOTAL and V_TOTAL must both be ≤ 1024. No other arithmetic overflow is possible.

## Timing

- Reset values, held during every cycle `reset` is high:
  - `hpos`=0, `vpos`=0.
  - All delay stages at idle, so `display_on`=0, `hsync`=1, `vsync`=1.
  - `frame`=0, `line_start`=0, `frame_start`=0.
- First cycle after reset release: counters at (0,0); `line_start`=`frame_start`=1.
- For the first SYNC_DLY cycles after release, delayed outputs still show idle values. Decode of counter state (h,v) appears on the delayed outputs exactly SYNC_DLY cycles later.
- Reset asserted mid-frame: outputs take reset values on the next edge. There is no partial-line completion and no glitch beyond idle levels.
- Frame period 420000 cycles; line period 800 cycles.

## Configuration

- `VGA_FRAME_CNT_EN` defined:
  - `frame` is an 8-bit register.
  - It increments on the same edge the counters wrap from (799,524) to (0,0), i.e. it updates coincident with `frame_start` rising.
  - It wraps 255→0 and is cleared by reset.
- Not defined: `frame` tied to 0; no register is inferred.

## Structure

- Package `vga_pkg`:
  - default timing constants for 640x480@60;
  - derived H_TOTAL/V_TOTAL and sync-start/end localparams;
  - `POS_W`=10.
- Sub-module `sync_delay` (parameters WIDTH, DEPTH, RESET_VAL): synchronous-reset shift register. Instantiated once, 3 bits wide, for {display_on, hsync, vsync}, with RESET_VAL {0,1,1}.

## Test plan

- Release reset, run 801 cycles → `hpos` walks 0..799, at cycle 800 reads 0 with `vpos`=1; `line_start` high at cycles 0 and 800 only.
- SYNC_DLY=2, observe one line → `hsync` low for exactly 96 consecutive cycles, first low cycle when `hpos`==658; `display_on` high for 640 cycles starting at `hpos`==2.
- Run two full frames → `frame_start` pulses exactly 420000 cycles apart; `vsync` low for 1600 cycles starting two cycles after (`hpos`,`vpos`)=(0,490); `display_on` high 307200 cycles per frame.
- Assert reset for one cycle at (`hpos`=300, `vpos`=100) → next cycle (0,0); `hsync`/`vsync`=1 and `display_on`=0 for SYNC_DLY cycles; `frame` back to 0.
- With `VGA_FRAME_CNT_EN`, run 256 frames → `frame` steps 0..255 then reads 0. Without the macro → `frame` stays 0 throughout.
- SYNC_DLY=1 and SYNC_DLY=8 → sync edges shift by exactly the parameter; pulse widths unchanged.
